gcd_initiator: RTL

- Requester side of the GCD start/done handshake. Buffers operand pairs from an upstream valid/ready stream and issues them one at a time to a GCD engine.
- The engine is driven through four ports: operands A and B, a one-cycle start pulse, and a done/result pair.
- Returns each result on a downstream valid/ready stream, in order, with an error flag.
- Sits between the host/test logic and the GCD engine wrapper. Owns operand stability, zero-operand handling and hang detection.

---
 rtl/gcd_pkg.sv | 23 ++
 rtl/gcd_req_fifo.sv | 65 ++++++
 rtl/gcd_initiator.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD requester: FSM encoding, default sizing and
// a counter-width helper.
package gcd_pkg;

    localparam int GCD_W_DEF       = 4;
    localparam int GCD_DEPTH_DEF   = 4;
    localparam int GCD_TIMEOUT_DEF = 64;
    localparam int GCD_GUARD_DEF   = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        GUARD_W = 3'd2,
        WAIT    = 3'd3,
        HOLD    = 3'd4
    } gcd_state_e;

    // Bits needed for a counter that must be able to hold the value n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/gcd_req_fifo.sv
// Show-ahead synchronous FIFO holding {A,B} operand pairs; DEPTH must be a power of 2.
module gcd_req_fifo
    import gcd_pkg::*;
#(
    parameter int DW    = 2 * GCD_W_DEF,
    parameter int DEPTH = GCD_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] pop_data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_q == AW'(gi))) begin
                    mem_q[gi] <= push_data_i;
                end
            end
        end
    endgenerate

    // Power-of-2 depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);

endmodule

// File: rtl/gcd_initiator.sv
// Requester side of the GCD start/done handshake: buffers operand pairs, runs
// them one at a time through the engine, returns results in order. Optional
// counters under GCD_INIT_STATS_EN.
module gcd_initiator
    import gcd_pkg::*;
#(
    parameter int W       = GCD_W_DEF,
    parameter int DEPTH   = GCD_DEPTH_DEF,
    parameter int TIMEOUT = GCD_TIMEOUT_DEF,
    parameter int GUARD   = GCD_GUARD_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         req_ready,
    output logic [W-1:0] gcd_a,
    output logic [W-1:0] gcd_b,
    output logic         gcd_start,
    input  logic         gcd_done,
    input  logic [W-1:0] gcd_result,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    output logic         res_err,
    input  logic         res_ready
`ifdef GCD_INIT_STATS_EN
    ,
    output logic [7:0]   op_count,
    output logic [3:0]   to_count
`endif
);

    localparam int TW = cnt_width(TIMEOUT);

    gcd_state_e   state_q, state_d;
    logic [W-1:0] gcd_a_q, gcd_a_d;
    logic [W-1:0] gcd_b_q, gcd_b_d;
    logic [W-1:0] res_data_q, res_data_d;
    logic         res_err_q, res_err_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic [2*W-1:0] fifo_head;
    logic [W-1:0]   head_a;
    logic [W-1:0]   head_b;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;

    gcd_req_fifo #(
        .DW    (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (req_valid && req_ready),
        .push_data_i ({req_a, req_b}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign head_a = fifo_head[2*W-1:W];
    assign head_b = fifo_head[W-1:0];

    always_comb begin
        state_d    = state_q;
        gcd_a_d    = gcd_a_q;
        gcd_b_d    = gcd_b_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        tmo_d      = tmo_q;
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head_a == '0) begin
                        res_data_d = head_b;
                        res_err_d  = 1'b0;
                        state_d    = HOLD;
                    end else if (head_b == '0) begin
                        res_data_d = head_a;
                        res_err_d  = 1'b0;
                        state_d    = HOLD;
                    end else begin
                        gcd_a_d = head_a;
                        gcd_b_d = head_b;
                        tmo_d   = '0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                tmo_d   = tmo_q + TW'(1);
                state_d = (GUARD == 0) ? WAIT : GUARD_W;
            end
            GUARD_W: begin
                // The same counter times the guard window: ISSUE is count 0.
                tmo_d = tmo_q + TW'(1);
                if (tmo_q >= TW'(GUARD)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                tmo_d = tmo_q + TW'(1);
                if (gcd_done) begin
                    res_data_d = gcd_result;
                    res_err_d  = 1'b0;
                    state_d    = HOLD;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gcd_a_q    <= '0;
            gcd_b_q    <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            gcd_a_q    <= gcd_a_d;
            gcd_b_q    <= gcd_b_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
            tmo_q      <= tmo_d;
        end
    end

    assign req_ready = !fifo_full;
    assign gcd_a     = gcd_a_q;
    assign gcd_b     = gcd_b_q;
    assign gcd_start = (state_q == ISSUE);
    assign res_valid = (state_q == HOLD);
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

`ifdef GCD_INIT_STATS_EN
    logic [7:0] op_count_q;
    logic [3:0] to_count_q;
    logic       timeout_evt;

    assign timeout_evt = (state_q == WAIT) && !gcd_done && (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            op_count_q <= '0;
            to_count_q <= '0;
        end else begin
            if (res_valid && res_ready && (op_count_q != 8'hFF)) begin
                op_count_q <= op_count_q + 8'd1;
            end
            if (timeout_evt && (to_count_q != 4'hF)) begin
                to_count_q <= to_count_q + 4'd1;
            end
        end
    end

    assign op_count = op_count_q;
    assign to_count = to_count_q;
`endif

endmodule
